// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the sequential PC, runs the SRAM-like instruction bus
// and presents one {pc, inst} at a time. Optional cancel counter enabled by FETCH_PERF_CNT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        post_allowin,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] cancel_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        CANCEL = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] seq_pc_q, seq_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;

    // Handshakes: a bus request is accepted on a cycle with inst_req && inst_addr_ok;
    // a response is consumed on inst_data_ok while a request is outstanding; the
    // fetch stage takes the presented word on out_valid && post_allowin.
    always_comb begin
        state_d     = state_q;
        seq_pc_d    = seq_pc_q;
        req_pc_d    = req_pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (inst_addr_ok) begin
                    req_pc_d = seq_pc_q;
                    seq_pc_d = seq_pc_q + PC_STEP;
                    state_d  = redirect_valid ? CANCEL : WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_d = inst_data_ok ? REQ : CANCEL;
                end else if (inst_data_ok) begin
                    out_pc_d    = req_pc_q;
                    out_inst_d  = inst_rdata;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || post_allowin) begin
                    out_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            // A response drained together with a new redirect leaves nothing in flight.
            CANCEL: if (inst_data_ok) state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) seq_pc_d = redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            seq_pc_q    <= RESET_PC;
            req_pc_q    <= 32'd0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            out_inst_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            seq_pc_q    <= seq_pc_d;
            req_pc_q    <= req_pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
        end
    end

    assign inst_req  = (state_q == REQ);
    assign inst_addr = seq_pc_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cancel_cnt_q, cancel_cnt_d;
    logic        discard;

    always_comb begin
        discard      = inst_data_ok &&
                       ((state_q == CANCEL) || ((state_q == WAIT) && redirect_valid));
        cancel_cnt_d = cancel_cnt_q + {31'd0, discard};
    end

    always_ff @(posedge clk) begin
        if (reset) cancel_cnt_q <= 32'd0;
        else       cancel_cnt_q <= cancel_cnt_d;
    end

    assign cancel_cnt = cancel_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic against a transaction-level
// model; presented instructions are checked by a scoreboard monitor.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        post_allowin;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cancel_cnt;
`endif

  fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .post_allowin   (post_allowin),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cancel_cnt     (cancel_cnt)
`endif
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  // reference model: fetch pointer, one outstanding bus transaction, one presented word
  logic        m_startup;
  logic        m_busy;
  logic        m_stale;
  logic        m_present;
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  logic [31:0] m_cancel;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every new presentation pops one expected {pc, inst}
  logic        mon_prev_valid = 1'b0;
  logic [63:0] mon_cur = 64'd0;
  always @(posedge clk) begin
    #2;
    if (out_valid === 1'b1) begin
      if (!mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_present: got pc %h inst %h, expected nothing", out_pc, out_inst);
        end else begin
          mon_cur = exp_q.pop_front();
          check32("present_pc", out_pc, mon_cur[63:32]);
          check32("present_inst", out_inst, mon_cur[31:0]);
        end
      end else begin
        check32("hold_pc", out_pc, mon_cur[63:32]);
        check32("hold_inst", out_inst, mon_cur[31:0]);
      end
    end
    mon_prev_valid = (out_valid === 1'b1);
  end

  // called at a negedge; leaves the DUT one cycle out of reset at the next negedge
  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    post_allowin   = 1'b0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_startup = 1'b1;
    m_busy    = 1'b0;
    m_stale   = 1'b0;
    m_present = 1'b0;
    m_pc      = RESET_PC;
    m_req_pc  = 32'd0;
    m_cancel  = 32'd0;
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_out_pc", out_pc, 32'd0);
    check32("rst_out_inst", out_inst, 32'd0);
    check32("rst_inst_req", {31'd0, inst_req}, 32'd0);
    check32("rst_inst_addr", inst_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
    check32("rst_cancel_cnt", cancel_cnt, 32'd0);
`endif
  endtask

  // driver task: called at a negedge, checks this cycle's outputs, applies inputs, steps the model
  task automatic cycle(input logic rv, input logic [31:0] rp, input logic aok,
                       input logic dok, input logic [31:0] rd, input logic pa);
    check32("inst_req", {31'd0, inst_req}, {31'd0, !m_startup && !m_busy && !m_present});
    check32("inst_addr", inst_addr, m_pc);
    check32("out_valid", {31'd0, out_valid}, {31'd0, m_present});
`ifdef FETCH_PERF_CNT_EN
    check32("cancel_cnt", cancel_cnt, m_cancel);
`endif
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_addr_ok   = aok;
    inst_data_ok   = dok;
    inst_rdata     = rd;
    post_allowin   = pa;
    if (m_startup) begin
      m_startup = 1'b0;
      if (rv) m_pc = rp;
    end else if (m_present) begin
      if (rv || pa) m_present = 1'b0;
      if (rv) m_pc = rp;
    end else if (!m_busy) begin
      if (aok) begin
        m_busy   = 1'b1;
        m_stale  = rv;
        m_req_pc = m_pc;
        m_pc     = rv ? rp : m_pc + 32'd4;
      end else if (rv) begin
        m_pc = rp;
      end
    end else begin
      if (dok) begin
        m_busy = 1'b0;
        if (m_stale || rv) m_cancel = m_cancel + 32'd1;
        else begin
          exp_q.push_back({m_req_pc, rd});
          m_present = 1'b1;
        end
      end else if (rv) begin
        m_stale = 1'b1;
      end
      if (rv) m_pc = rp;
    end
    @(negedge clk);
  endtask

  initial begin
    logic        rv, aok, dok, pa;
    logic [31:0] rp;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    post_allowin   = 1'b0;
    inst_addr_ok   = 1'b0;
    inst_data_ok   = 1'b0;
    inst_rdata     = 32'd0;
    @(negedge clk);
    do_reset();

    // first fetch, one-cycle response, immediate acceptance
    cycle(0, 0, 0, 0, 0, 1);
    check32("first_addr", inst_addr, 32'hBFC0_0000);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 1, 32'h2402_0001, 1);
    check32("t1_out_inst", out_inst, 32'h2402_0001);
    cycle(0, 0, 0, 0, 0, 1);
    check32("t1_next_addr", inst_addr, 32'hBFC0_0004);

    // back-pressure in HOLD
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h1234_5678, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
    check32("t2_held_pc", out_pc, 32'hBFC0_0004);
    cycle(0, 0, 0, 0, 0, 1);
    check32("t2_valid_drop", {31'd0, out_valid}, 32'd0);
    check32("t2_next_addr", inst_addr, 32'hBFC0_0008);

    // redirect on the addr_ok cycle: stale request, next fetch at the target itself
    cycle(1, 32'h8000_1000, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hCAFE_0001, 0);
    check32("t4_redirect_addr", inst_addr, 32'h8000_1000);

    // redirect in WAIT, late response discarded
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 32'h8000_0180, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    check32("t3_redirect_addr", inst_addr, 32'h8000_0180);
    check32("t3_no_present", {31'd0, out_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check32("t3_cancel_cnt", cancel_cnt, 32'd2);
`endif

    // redirect in HOLD voids the handshake
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0000_0AAA, 0);
    cycle(1, 32'h9000_0000, 0, 0, 0, 1);
    check32("t5_valid_drop", {31'd0, out_valid}, 32'd0);
    check32("t5_redirect_addr", inst_addr, 32'h9000_0000);

    // sequential PC wraps past the top of the address space
    cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    check32("wrap_addr", inst_addr, 32'h0000_0000);
    cycle(0, 0, 0, 1, 32'h0BAD_F00D, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // reset while waiting, then stray responses
    cycle(0, 0, 1, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 1, 32'h5555_AAAA, 1);
    cycle(0, 0, 0, 1, 32'h5555_AAAA, 1);
    check32("t6_first_addr", inst_addr, RESET_PC);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        rv  = ($urandom_range(0, 7) == 0);
        rp  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
        aok = ($urandom_range(0, 1) == 1);
        dok = m_busy && ($urandom_range(0, 1) == 1);
        pa  = ($urandom_range(0, 2) != 0);
        cycle(rv, rp, aok, dok, $urandom(), pa);
      end
    end

    // drain: let any presented word be taken, issue nothing new
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, m_busy, $urandom(), 1);
    check32("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
